// File: rtl/dmem_access_ctrl.sv
// dmem_access_ctrl
//   Multi-cycle load/store initiator in front of a word-addressed 32-bit
//   data memory with combinational read and level-sensitive write.
//   Loads read the addressed word and extract/extend the selected lane.
//   Sub-word stores read the word first and write back a merged word.
//   Every write pulse is framed by a SETUP and a HOLD cycle, so the
//   address and data stay stable around write_en.
module dmem_access_ctrl #(
    parameter int MEM_WORDS = 256,
    parameter int ADDR_W    = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    // request channel from the datapath control FSM
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [1:0]        req_size,
    input  logic              req_signed,
    input  logic [ADDR_W+1:0] req_addr,
    input  logic [31:0]       req_wdata,
    // response channel
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [31:0]       resp_rdata,
    output logic              resp_err,
    // memory side
    output logic [ADDR_W-1:0] data_address,
    output logic              write_en,
    output logic [31:0]       write_data,
    input  logic [31:0]       read_data
);

    // Controller states
    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_RD    = 3'd1;
    localparam logic [2:0] S_SETUP = 3'd2;
    localparam logic [2:0] S_WR    = 3'd3;
    localparam logic [2:0] S_HOLD  = 3'd4;
    localparam logic [2:0] S_RESP  = 3'd5;

    // Access size encodings; 2'b11 is illegal
    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    localparam logic [31:0] MEM_WORDS_U = 32'(MEM_WORDS);

    // Extract the addressed lane of a memory word and zero/sign extend it.
    function automatic logic [31:0] extract_load(
        input logic [31:0] word,
        input logic [1:0]  size,
        input logic [1:0]  lane,
        input logic        sext
    );
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        b = word[{lane, 3'b000} +: 8];
        h = lane[1] ? word[31:16] : word[15:0];
        case (size)
            SZ_BYTE: r = {{24{sext & b[7]}}, b};
            SZ_HALF: r = {{16{sext & h[15]}}, h};
            default: r = word;
        endcase
        return r;
    endfunction

    // Replace only the addressed lane of the current word with store data.
    function automatic logic [31:0] merge_store(
        input logic [31:0] word,
        input logic [31:0] wdata,
        input logic [1:0]  size,
        input logic [1:0]  lane
    );
        logic [31:0] m;
        m = word;
        case (size)
            SZ_BYTE: m[{lane, 3'b000} +: 8] = wdata[7:0];
            SZ_HALF: begin
                if (lane[1]) begin
                    m[31:16] = wdata[15:0];
                end else begin
                    m[15:0] = wdata[15:0];
                end
            end
            default: m = wdata;
        endcase
        return m;
    endfunction

    // Control state and registered outputs
    logic [2:0]        state_q,        state_d;
    logic [ADDR_W-1:0] data_address_q, data_address_d;
    logic [31:0]       write_data_q,   write_data_d;
    logic              write_en_q,     write_en_d;
    logic              resp_valid_q,   resp_valid_d;
    logic              resp_err_q,     resp_err_d;
    logic [31:0]       resp_rdata_q,   resp_rdata_d;

    // Request fields captured at acceptance
    logic              write_q;
    logic [1:0]        size_q;
    logic              signed_q;
    logic [1:0]        lane_q;
    logic [31:0]       wdata_q;

    // Decoded view of the incoming request
    logic              accept;
    logic [ADDR_W-1:0] req_idx;
    logic [1:0]        req_lane;
    logic              req_err;
    logic              req_word_store;

    assign accept         = (state_q == S_IDLE) && req_valid;
    assign req_idx        = req_addr[ADDR_W+1:2];
    assign req_lane       = req_addr[1:0];
    assign req_word_store = req_write && (req_size == SZ_WORD);

    // Misaligned, out-of-range or illegal-size requests never touch memory
    always_comb begin
        req_err = 1'b0;
        if (req_size == 2'b11) begin
            req_err = 1'b1;
        end
        if ((req_size == SZ_HALF) && req_lane[0]) begin
            req_err = 1'b1;
        end
        if ((req_size == SZ_WORD) && (req_lane != 2'b00)) begin
            req_err = 1'b1;
        end
        if (32'(req_idx) >= MEM_WORDS_U) begin
            req_err = 1'b1;
        end
    end

    // Next-state and next-output computation for the access sequencer
    always_comb begin
        state_d        = state_q;
        data_address_d = data_address_q;
        write_data_d   = write_data_q;
        resp_err_d     = resp_err_q;
        resp_rdata_d   = resp_rdata_q;

        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    resp_rdata_d = 32'h0;
                    if (req_err) begin
                        // data_address is left alone: no memory access at all
                        resp_err_d = 1'b1;
                        state_d    = S_RESP;
                    end else begin
                        resp_err_d     = 1'b0;
                        data_address_d = req_idx;
                        if (req_word_store) begin
                            // full word needs no read; data is ready for SETUP
                            write_data_d = req_wdata;
                            state_d      = S_SETUP;
                        end else begin
                            state_d = S_RD;
                        end
                    end
                end
            end
            S_RD: begin
                if (write_q) begin
                    write_data_d = merge_store(read_data, wdata_q, size_q, lane_q);
                    state_d      = S_SETUP;
                end else begin
                    resp_rdata_d = extract_load(read_data, size_q, lane_q, signed_q);
                    state_d      = S_RESP;
                end
            end
            S_SETUP: state_d = S_WR;
            S_WR:    state_d = S_HOLD;
            S_HOLD:  state_d = S_RESP;
            S_RESP: begin
                if (resp_ready) begin
                    resp_err_d   = 1'b0;
                    resp_rdata_d = 32'h0;
                    state_d      = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Strobes follow the state being entered so they are glitch-free flops
        write_en_d   = (state_d == S_WR);
        resp_valid_d = (state_d == S_RESP);
    end

    // Sequencer state and memory/response outputs, cleared asynchronously
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= S_IDLE;
            data_address_q <= '0;
            write_data_q   <= 32'h0;
            write_en_q     <= 1'b0;
            resp_valid_q   <= 1'b0;
            resp_err_q     <= 1'b0;
            resp_rdata_q   <= 32'h0;
        end else begin
            state_q        <= state_d;
            data_address_q <= data_address_d;
            write_data_q   <= write_data_d;
            write_en_q     <= write_en_d;
            resp_valid_q   <= resp_valid_d;
            resp_err_q     <= resp_err_d;
            resp_rdata_q   <= resp_rdata_d;
        end
    end

    // Request capture; pure data, only meaningful after an acceptance
    always_ff @(posedge clk) begin
        if (accept) begin
            write_q  <= req_write;
            size_q   <= req_size;
            signed_q <= req_signed;
            lane_q   <= req_lane;
            wdata_q  <= req_wdata;
        end
    end

    assign req_ready    = (state_q == S_IDLE);
    assign resp_valid   = resp_valid_q;
    assign resp_err     = resp_err_q;
    assign resp_rdata   = resp_rdata_q;
    assign data_address = data_address_q;
    assign write_en     = write_en_q;
    assign write_data   = write_data_q;

endmodule
